// File: rtl/fir_decimator.sv
// Decimating back end for an FIR filter: averages every 2^DECIM_LOG2 input sums, rounds,
// saturates and queues the result in a two-entry output FIFO with a sticky drop flag.
module fir_decimator #(
    parameter int unsigned BW_IN      = 13,
    parameter int unsigned BW_OUT     = 8,
    parameter int unsigned DECIM_LOG2 = 2,
    parameter int unsigned SHIFT      = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [BW_IN-1:0]  in_data,
    input  logic                     in_valid,
    output logic signed [BW_OUT-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     overflow
);

    localparam int unsigned D      = 1 << DECIM_LOG2;
    localparam int unsigned ACC_W  = BW_IN + DECIM_LOG2;
    localparam int unsigned SUM_W  = ACC_W + 1;
    localparam int unsigned K      = DECIM_LOG2 + SHIFT;
    localparam int unsigned CNT_W  = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam int unsigned WIDE_W = ((SUM_W > BW_OUT) ? SUM_W : BW_OUT) + 1;

    localparam logic signed [SUM_W-1:0]  RND     = (K > 0) ? (SUM_W'(1) << (K - 1)) : '0;
    localparam logic signed [WIDE_W-1:0] SAT_MAX = WIDE_W'((2 ** (BW_OUT - 1)) - 1);
    localparam logic signed [WIDE_W-1:0] SAT_MIN = ~SAT_MAX;

    logic        [CNT_W-1:0]  cnt_q, cnt_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  total;
    logic signed [SUM_W-1:0]  rounded;
    logic signed [WIDE_W-1:0] wide;
    logic signed [BW_OUT-1:0] result;
    logic                     last_sample;

    logic signed [BW_OUT-1:0] mem_q [2];
    logic                     rd_ptr_q, rd_ptr_d;
    logic                     wr_ptr_q, wr_ptr_d;
    logic        [1:0]        count_q, count_d;
    logic                     overflow_q, overflow_d;
    logic                     push, pop, full, accept;

    assign last_sample = (cnt_q == CNT_W'(D - 1));

    // The one-bit headroom in SUM_W keeps the rounding offset from wrapping.
    assign total   = acc_q + ACC_W'(in_data);
    assign rounded = (SUM_W'(total) + RND) >>> K;
    assign wide    = WIDE_W'(rounded);

    always_comb begin
        result = wide[BW_OUT-1:0];
        if (wide > SAT_MAX) begin
            result = SAT_MAX[BW_OUT-1:0];
        end else if (wide < SAT_MIN) begin
            result = SAT_MIN[BW_OUT-1:0];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (in_valid) begin
            if (last_sample) begin
                cnt_d = '0;
                acc_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                acc_d = total;
            end
        end
    end

    assign push   = in_valid && last_sample;
    assign pop    = out_valid && out_ready;
    assign full   = (count_q == 2'd2);
    // A pop on the same edge frees the slot the new result needs.
    assign accept = push && (!full || pop);

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (accept) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (accept && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !accept) begin
            count_d = count_q - 2'd1;
        end
        if (push && !accept) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            overflow_q <= 1'b0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (accept) begin
                mem_q[wr_ptr_q] <= result;
            end
        end
    end

    assign out_valid = (count_q != 2'd0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_fir_decimator.sv
// Scoreboard bench for fir_decimator: a sample-list reference model queues expected results,
// and a negedge monitor compares them against the output FIFO, overflow flag and idle state.
module tb_fir_decimator;

    localparam int BW_IN      = 13;
    localparam int BW_OUT     = 8;
    localparam int DECIM_LOG2 = 2;
    localparam int SHIFT      = 0;
    localparam int D          = 1 << DECIM_LOG2;

    logic                     clk;
    logic                     reset;
    logic signed [BW_IN-1:0]  in_data;
    logic                     in_valid;
    logic signed [BW_OUT-1:0] out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     overflow;

    fir_decimator #(
        .BW_IN      (BW_IN),
        .BW_OUT     (BW_OUT),
        .DECIM_LOG2 (DECIM_LOG2),
        .SHIFT      (SHIFT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     n_tests = 0;
    int     n_fail  = 0;
    longint exp_q[$];
    longint m_samples[$];
    bit     m_ovf = 1'b0;

    function automatic longint ref_result(longint total);
        int     k;
        longint r;
        longint hi;
        longint lo;
        k  = DECIM_LOG2 + SHIFT;
        r  = (k > 0) ? ((total + (longint'(1) << (k - 1))) >>> k) : total;
        hi = (longint'(1) << (BW_OUT - 1)) - 1;
        lo = -(longint'(1) << (BW_OUT - 1));
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return r;
    endfunction

    // Reference model: collect D accepted samples, average them, offer to a 2-deep queue.
    always @(posedge clk) begin
        if (!reset && in_valid) begin
            m_samples.push_back(longint'(in_data));
            if (m_samples.size() == D) begin
                longint total;
                total = 0;
                foreach (m_samples[i]) total += m_samples[i];
                m_samples.delete();
                // The monitor already removed the entry popped on this edge.
                if (exp_q.size() < 2) exp_q.push_back(ref_result(total));
                else m_ovf = 1'b1;
            end
        end
    end

    task automatic check(input string name, input longint act, input longint req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        check("overflow", longint'(overflow), longint'(m_ovf));
        if (exp_q.size() > 0) begin
            check("out_valid", longint'(out_valid), 1);
            check("out_data", longint'(out_data), exp_q[0]);
            if (out_ready) void'(exp_q.pop_front());
        end else begin
            check("idle_valid", longint'(out_valid), 0);
            check("idle_data", longint'(out_data), 0);
        end
    end

    task automatic drive(input bit v, input int d, input bit r);
        in_valid  = v;
        in_data   = BW_IN'(d);
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        m_samples.delete();
        m_ovf = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic feed4(input int a, input int b, input int c, input int e, input bit r);
        drive(1'b1, a, r);
        drive(1'b1, b, r);
        drive(1'b1, c, r);
        drive(1'b1, e, r);
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) drive(1'b0, 0, r);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Basic average, then rounding cases.
        feed4(10, 20, 30, 40, 1'b1);
        idle(3, 1'b1);
        feed4(1, 1, 0, 0, 1'b1);
        feed4(1, 0, 0, 0, 1'b1);
        feed4(-1, -1, 0, 0, 1'b1);
        feed4(-2, -1, 0, 0, 1'b1);
        idle(2, 1'b1);

        // Saturation at both rails; gaps in in_valid must not disturb counting.
        feed4(4095, 4095, 4095, 4095, 1'b1);
        drive(1'b1, -4096, 1'b1);
        drive(1'b0, 1234, 1'b1);
        drive(1'b1, -4096, 1'b1);
        drive(1'b0, -77, 1'b1);
        drive(1'b1, -4096, 1'b1);
        drive(1'b1, -4096, 1'b1);
        idle(2, 1'b1);

        // Backpressure: third result dropped, then drain.
        feed4(5, 5, 5, 5, 1'b0);
        feed4(6, 6, 6, 6, 1'b0);
        feed4(7, 7, 7, 7, 1'b0);
        idle(2, 1'b0);
        idle(4, 1'b1);

        // Full FIFO with a pop on the edge a new result arrives.
        do_reset();
        feed4(1, 1, 1, 1, 1'b0);
        feed4(2, 2, 2, 2, 1'b0);
        drive(1'b1, 9, 1'b0);
        drive(1'b1, 9, 1'b0);
        drive(1'b1, 9, 1'b0);
        drive(1'b1, 9, 1'b1);
        idle(4, 1'b1);

        // Reset mid-accumulation discards the partial sum.
        drive(1'b1, 100, 1'b1);
        drive(1'b1, 100, 1'b1);
        do_reset();
        feed4(8, 8, 8, 8, 1'b1);
        idle(3, 1'b1);

        // Randomized traffic with varying consumer pressure and one mid-run reset.
        for (int phase = 0; phase < 4; phase++) begin
            for (int i = 0; i < 600; i++) begin
                bit v;
                bit r;
                int d;
                v = ($urandom_range(0, 9) < 7);
                r = ($urandom_range(0, 3) < phase + 1);
                case ($urandom_range(0, 3))
                    0:       d = 4095 - int'($urandom_range(0, 3));
                    1:       d = -4096 + int'($urandom_range(0, 3));
                    2:       d = int'($urandom_range(0, 16)) - 8;
                    default: d = int'($urandom_range(0, 8191)) - 4096;
                endcase
                drive(v, d, r);
                if (phase == 1 && i == 300) do_reset();
            end
        end

        idle(6, 1'b1);
        check("drained", longint'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
